e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline, sitting beside the single-cycle ALU and sharing its operand buses. Unlike the ALU, it accepts an operation in one cycle and returns the result in the HI/LO pair several cycles later, holding `busy` meanwhile so the hazard unit can stall dependent instructions. It also serves `mfhi`/`mflo` reads and `mthi`/`mtlo` writes.

## Interface
- `MULT_CYCLES`, 5, cycles `busy` stays high for `mult`/`multu`
- `DIV_CYCLES`, 10, cycles `busy` stays high for `div`/`divu`
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `A` in 32: rs operand (forwarded)
- `B` in 32: rt operand (forwarded)
- `MDUOp` in 4: operation code, `MDU_*` constants
- `start` in 1: accept a `mult`/`multu`/`div`/`divu` this cycle
- `busy` out 1: an operation is in flight
- `HI` out 32: architectural HI register
- `LO` out 32: architectural LO register
- `C` out 32: `mfhi`/`mflo` read data, combinational

## Operation
- Opcodes: `MDU_none`, `MDU_mult`, `MDU_multu`, `MDU_div`, `MDU_divu`, `MDU_mfhi`, `MDU_mflo`, `MDU_mthi`, `MDU_mtlo`.
- States: IDLE, BUSY. A 4-bit down-counter `cnt` drives BUSY.
- IDLE and `start`=1 with a mul/div op: latch the 64-bit result into hidden `hi_q`/`lo_q`, load `cnt`=MULT_CYCLES-1 or DIV_CYCLES-1, go to BUSY.
- BUSY: decrement `cnt` each cycle. When it reaches 0, copy `hi_q`/`lo_q` to HI/LO and return to IDLE.
- `start` while BUSY: ignored. The hazard unit must stall, so this indicates a bench error.
- Arithmetic:
  - `mult`: {HI,LO} = $signed(A)*$signed(B), 64-bit.
  - `multu`: {HI,LO} = A*B, unsigned 64-bit.
  - `div`: LO = $signed(A)/$signed(B), HI = $signed(A)%$signed(B); quotient truncates toward zero, remainder takes the sign of A.
  - `divu`: the same, unsigned.
- Divide by zero (B=0): counter runs normally, but HI/LO stay unchanged at completion.
- `div` with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- `mthi`/`mtlo` (IDLE only): HI or LO ← A at the next edge; `start` is not used.
- `mfhi`/`mflo`: C = HI or LO combinationally. For any other op, C = 0.
- `busy` = (state==BUSY). The stall condition is `start|busy` combined with an MDU-class op in D; that logic lives outside this block.

## Timing
- Reset: state=IDLE, cnt=0, HI=0, LO=0, `hi_q`/`lo_q`=0, `busy`=0.
- Reset during BUSY: abort immediately, with no HI/LO update.
- `start` at edge t: `busy`=1 from t+1 through t+N, where N is MULT_CYCLES or DIV_CYCLES. HI/LO take the new value at edge t+N, and `busy`=0 from that cycle on.
- Back-to-back: a new `start` is accepted in the first cycle `busy`=0.
- `mthi`/`mtlo` take effect one edge after issue. A following `mfhi`/`mflo` sees the new value.
- `mthi` and `start` in the same cycle cannot occur, since MDUOp is a single field.
- `C` has zero latency and reflects HI/LO as currently registered.

## Structure
- Add `MDU_*` opcode defines (4-bit) to the shared `def.v`, alongside the `ALU_*` codes. Control decode emits `MDUOp` and `start` from there.
- Keep the cycle constants as module parameters, not globals.
- No sub-module. Implement arithmetic with behavioural `*` and `/`/`%` in the start cycle, with the counter modelling latency.
- Estimated 130–180 lines.

## Test plan
- Reset, then `mult`: A=0xFFFFFFFE (-2), B=3, `start` → `busy` high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- `multu`: A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- `div`: A=-7 (0xFFFFFFF9), B=2 → `busy` high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. `divu` on the same operands → LO=0x7FFFFFFC, HI=1.
- `mthi` A=0x12345678, next cycle `mfhi` → C=0x12345678. `mtlo` 0xA5A5A5A5 then `div` with B=0 → after 10 cycles LO is still 0xA5A5A5A5.
- `mult` started, `reset` asserted on the 3rd busy cycle → next cycle `busy`=0, HI=LO=0. A new `mult` 6×7 → LO=42 after 5 cycles.
- Extra `start` pulsed mid-`div` → ignored; `busy` deasserts exactly 10 cycles after the first `start`, and the result matches the first operands.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared opcode and state definitions for the execute-stage multiply/divide unit.
package e_mdu_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [3:0] {
    MDU_none  = 4'd0,
    MDU_mult  = 4'd1,
    MDU_multu = 4'd2,
    MDU_div   = 4'd3,
    MDU_divu  = 4'd4,
    MDU_mfhi  = 4'd5,
    MDU_mflo  = 4'd6,
    MDU_mthi  = 4'd7,
    MDU_mtlo  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  function automatic logic isMulDiv(input mdu_op_e op);
    return (op == MDU_mult) || (op == MDU_multu) || (op == MDU_div) || (op == MDU_divu);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
interface e_mdu_if;
  import e_mdu_pkg::*;

  logic [31:0] A;
  logic [31:0] B;
  mdu_op_e     MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] C;

  modport master (output A, B, MDUOp, start, input busy, HI, LO, C);
  modport slave  (input A, B, MDUOp, start, output busy, HI, LO, C);

endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit: the result is computed in the start cycle and
// held in hidden registers until a down-counter expires, then committed to HI/LO.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  bus
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hiArch_q, hiArch_d, loArch_q, loArch_d;

  logic [63:0] prodS, prodU;
  logic [31:0] absA, absB, magQ, magR, quotS, remS, quotU, remU;

  // Signed division works on magnitudes so that 0x80000000 / -1 wraps cleanly
  // to 0x80000000 with remainder 0 instead of trapping.
  always_comb begin
    prodS = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    prodU = {32'd0, bus.A} * {32'd0, bus.B};
    absA  = bus.A[31] ? (32'd0 - bus.A) : bus.A;
    absB  = bus.B[31] ? (32'd0 - bus.B) : bus.B;
    magQ  = absA / absB;
    magR  = absA % absB;
    quotS = (bus.A[31] ^ bus.B[31]) ? (32'd0 - magQ) : magQ;
    remS  = bus.A[31] ? (32'd0 - magR) : magR;
    quotU = bus.A / bus.B;
    remU  = bus.A % bus.B;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hiArch_d = hiArch_q;
    loArch_d = loArch_q;
    case (state_q)
      IDLE: begin
        if (bus.start && isMulDiv(bus.MDUOp)) begin
          state_d = BUSY;
          // A zero divisor re-latches the current HI/LO so the commit is a no-op.
          hi_d    = hiArch_q;
          lo_d    = loArch_q;
          case (bus.MDUOp)
            MDU_mult: begin
              cnt_d = CNT_W'(MULT_CYCLES - 1);
              hi_d  = prodS[63:32];
              lo_d  = prodS[31:0];
            end
            MDU_multu: begin
              cnt_d = CNT_W'(MULT_CYCLES - 1);
              hi_d  = prodU[63:32];
              lo_d  = prodU[31:0];
            end
            MDU_div: begin
              cnt_d = CNT_W'(DIV_CYCLES - 1);
              if (bus.B != 32'd0) begin
                hi_d = remS;
                lo_d = quotS;
              end
            end
            default: begin
              cnt_d = CNT_W'(DIV_CYCLES - 1);
              if (bus.B != 32'd0) begin
                hi_d = remU;
                lo_d = quotU;
              end
            end
          endcase
        end else if (bus.MDUOp == MDU_mthi) begin
          hiArch_d = bus.A;
        end else if (bus.MDUOp == MDU_mtlo) begin
          loArch_d = bus.A;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          hiArch_d = hi_q;
          loArch_d = lo_q;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hiArch_q <= '0;
      loArch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hiArch_q <= hiArch_d;
      loArch_q <= loArch_d;
    end
  end

  assign bus.busy = (state_q == BUSY);
  assign bus.HI   = hiArch_q;
  assign bus.LO   = loArch_q;
  assign bus.C    = (bus.MDUOp == MDU_mfhi) ? hiArch_q :
                    (bus.MDUOp == MDU_mflo) ? loArch_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus pushes expected results computed with plain
// 64-bit arithmetic, and a monitor checks them when busy drops or a move-from is shown.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  e_mdu_if mduIf();

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (mduIf.slave)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t        opQ[$];
  logic [31:0] cQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;
  bit          expectAbort = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference semantics straight from the architecture, using 64-bit integers.
  function automatic void refModel(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] hi, inout logic [31:0] lo);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MDU_mult: begin
        sp = sa * sb;
        hi = sp[63:32];
        lo = sp[31:0];
      end
      MDU_multu: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      MDU_div: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        lo = sq[31:0];
        hi = sr[31:0];
      end
      MDU_divu: if (b != 0) begin
        lo = a / b;
        hi = a % b;
      end
      default: ;
    endcase
  endfunction

  task automatic waitIdle(input string name);
    int n = 0;
    while (mduIf.busy !== 1'b0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s timeout: busy still %b, expected 0", name, mduIf.busy);
    end
  endtask

  task automatic pushExpect(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t e;
    logic [31:0] h, l;
    h = modelHi;
    l = modelLo;
    refModel(op, a, b, h, l);
    modelHi  = h;
    modelLo  = l;
    e.hi     = h;
    e.lo     = l;
    e.cycles = (op == MDU_mult || op == MDU_multu) ? MULT_N : DIV_N;
    e.name   = name;
    opQ.push_back(e);
  endtask

  task automatic applyStimulus(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b, input string name);
    pushExpect(op, a, b, name);
    mduIf.A = a;
    mduIf.B = b;
    mduIf.MDUOp = op;
    mduIf.start = 1'b1;
    @(posedge clk); #1;
    mduIf.start = 1'b0;
    mduIf.MDUOp = MDU_none;
    waitIdle(name);
  endtask

  task automatic moveTo(input mdu_op_e op, input logic [31:0] val);
    mduIf.A = val;
    mduIf.MDUOp = op;
    @(posedge clk); #1;
    mduIf.MDUOp = MDU_none;
    if (op == MDU_mthi) modelHi = val;
    else modelLo = val;
  endtask

  task automatic moveFrom(input mdu_op_e op);
    cQ.push_back(op == MDU_mfhi ? modelHi : modelLo);
    mduIf.MDUOp = op;
    @(posedge clk); #1;
    mduIf.MDUOp = MDU_none;
  endtask

  // Monitor: counts busy cycles and checks HI/LO whenever busy falls, plus C on reads.
  initial begin
    int   busyCnt = 0;
    logic prevBusy = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mduIf.busy === 1'b1) begin
        busyCnt++;
      end else if (prevBusy === 1'b1) begin
        if (expectAbort) begin
          expectAbort = 1'b0;
          checkOutput("abort HI", mduIf.HI, 32'd0);
          checkOutput("abort LO", mduIf.LO, 32'd0);
        end else if (opQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected completion: busy fell after %0d cycles, expected none", busyCnt);
        end else begin
          e = opQ.pop_front();
          checkOutput({e.name, " busy cycles"}, 32'(busyCnt), 32'(e.cycles));
          checkOutput({e.name, " HI"}, mduIf.HI, e.hi);
          checkOutput({e.name, " LO"}, mduIf.LO, e.lo);
        end
        busyCnt = 0;
      end
      if ((mduIf.MDUOp == MDU_mfhi || mduIf.MDUOp == MDU_mflo) && cQ.size() > 0)
        checkOutput(mduIf.MDUOp == MDU_mfhi ? "mfhi C" : "mflo C", mduIf.C, cQ.pop_front());
      prevBusy = mduIf.busy;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    mdu_op_e ops[4] = '{MDU_mult, MDU_multu, MDU_div, MDU_divu};
    logic [31:0] ra, rb;
    mdu_op_e rop;

    mduIf.A = 32'd0;
    mduIf.B = 32'd0;
    mduIf.MDUOp = MDU_none;
    mduIf.start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset busy", 32'(mduIf.busy), 32'd0);
    checkOutput("reset HI", mduIf.HI, 32'd0);
    checkOutput("reset LO", mduIf.LO, 32'd0);
    checkOutput("reset C", mduIf.C, 32'd0);

    applyStimulus(MDU_mult,  32'hFFFFFFFE, 32'd3, "mult -2*3");
    applyStimulus(MDU_multu, 32'hFFFFFFFF, 32'd2, "multu");
    applyStimulus(MDU_div,   32'hFFFFFFF9, 32'd2, "div -7/2");
    applyStimulus(MDU_divu,  32'hFFFFFFF9, 32'd2, "divu");
    applyStimulus(MDU_div,   32'h80000000, 32'hFFFFFFFF, "div overflow");

    moveTo(MDU_mthi, 32'h12345678);
    moveFrom(MDU_mfhi);
    moveTo(MDU_mtlo, 32'hA5A5A5A5);
    applyStimulus(MDU_div, 32'd99, 32'd0, "div by zero");
    moveFrom(MDU_mflo);

    // Reset on the third busy cycle of a multiply aborts it without a commit.
    mduIf.A = 32'd11;
    mduIf.B = 32'd13;
    mduIf.MDUOp = MDU_mult;
    mduIf.start = 1'b1;
    @(posedge clk); #1;
    mduIf.start = 1'b0;
    mduIf.MDUOp = MDU_none;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    expectAbort = 1'b1;
    modelHi = 32'd0;
    modelLo = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("post-reset busy", 32'(mduIf.busy), 32'd0);
    applyStimulus(MDU_mult, 32'd6, 32'd7, "mult 6*7");

    // An extra start mid-divide must be ignored.
    pushExpect(MDU_div, 32'd1000, 32'hFFFFFFFD, "div with extra start");
    mduIf.A = 32'd1000;
    mduIf.B = 32'hFFFFFFFD;
    mduIf.MDUOp = MDU_div;
    mduIf.start = 1'b1;
    @(posedge clk); #1;
    mduIf.start = 1'b0;
    mduIf.MDUOp = MDU_none;
    repeat (3) @(posedge clk);
    #1;
    mduIf.A = 32'd6;
    mduIf.B = 32'd7;
    mduIf.MDUOp = MDU_mult;
    mduIf.start = 1'b1;
    @(posedge clk); #1;
    mduIf.start = 1'b0;
    mduIf.MDUOp = MDU_none;
    waitIdle("div with extra start");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      case ($urandom_range(0, 5))
        4: begin
          moveTo(MDU_mthi, ra);
          moveFrom(MDU_mfhi);
        end
        5: begin
          moveTo(MDU_mtlo, ra);
          moveFrom(MDU_mflo);
        end
        default: begin
          rop = ops[$urandom_range(0, 3)];
          applyStimulus(rop, ra, rb, "random op");
          moveFrom(MDU_mfhi);
          moveFrom(MDU_mflo);
        end
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    if (opQ.size() != 0 || cQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL pending expectations: got %0d left, expected 0", opQ.size() + cQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
